// File: rtl/pipe_cl_adder_pkg.sv
// Shared types and defaults for the pipelined carry-lookahead adder.
// Optional flag outputs are enabled with PIPE_CL_ADDER_FLAGS_EN.
package pipe_cl_adder_pkg;

  localparam int DefWidth      = 32;
  localparam int DefBlockWidth = 8;

  typedef struct packed {
    logic valid;
    logic carry;
    logic zero;
    logic msb_carry;
  } stage_t;

  function automatic int stages(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/cl_adder_w_cin.sv
// Combinational carry-lookahead adder with carry in/out.
module cl_adder_w_cin #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             carry_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);
  logic [Width-1:0] w_g, w_p;
  logic [Width:0]   w_c;

  // each carry is the flattened generate/propagate expression over all lower bits
  always_comb begin
    w_g    = a_i & b_i;
    w_p    = a_i ^ b_i;
    w_c    = '0;
    w_c[0] = carry_i;
    for (int i = 0; i < Width; i++) begin
      w_c[i+1] = carry_i;
      for (int j = 0; j <= i; j++) w_c[i+1] = w_g[j] | (w_p[j] & w_c[i+1]);
    end
  end

  assign sum_o   = w_p ^ w_c[Width-1:0];
  assign carry_o = w_c[Width];

endmodule

// File: rtl/pipe_cl_adder_stage.sv
// One slice of the pipelined adder: lookahead add plus, with
// PIPE_CL_ADDER_FLAGS_EN, the carry into the slice MSB and a slice-zero bit.
module pipe_cl_adder_stage
  import pipe_cl_adder_pkg::*;
#(
  parameter int BlockWidth = DefBlockWidth
) (
  input  logic [BlockWidth-1:0] a_i,
  input  logic [BlockWidth-1:0] b_i,
  input  logic                  carry_i,
  output logic [BlockWidth-1:0] sum_o,
  output logic                  carry_o
`ifdef PIPE_CL_ADDER_FLAGS_EN
  ,
  output logic                  msb_carry_o,
  output logic                  zero_o
`endif
);
  cl_adder_w_cin #(.Width(BlockWidth)) u_add (
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
    .sum_o   (sum_o),
    .carry_o (carry_o)
  );

`ifdef PIPE_CL_ADDER_FLAGS_EN
  // sum = a ^ b ^ cin, so the MSB carry-in is recovered with one XOR
  assign msb_carry_o = sum_o[BlockWidth-1] ^ a_i[BlockWidth-1] ^ b_i[BlockWidth-1];
  assign zero_o      = ~|sum_o;
`endif

endmodule

// File: rtl/pipe_cl_adder.sv
// Pipelined carry-lookahead adder/subtractor, one slice per stage, valid/ready.
// Define PIPE_CL_ADDER_FLAGS_EN to add overflow_o and zero_o.
module pipe_cl_adder
  import pipe_cl_adder_pkg::*;
#(
  parameter int Width      = DefWidth,
  parameter int BlockWidth = DefBlockWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o
`ifdef PIPE_CL_ADDER_FLAGS_EN
  ,
  output logic             overflow_o,
  output logic             zero_o
`endif
);
  localparam int Stages = stages(Width, BlockWidth);

  if (Width % BlockWidth != 0) begin : g_cfg_err
    $error("pipe_cl_adder: Width must be a multiple of BlockWidth");
  end

  logic w_adv;

  for (genvar k = 0; k < Stages; k++) begin : g_st
    localparam int Rem = Width - (k + 1) * BlockWidth;

    stage_t                        r_st;
    logic [(k+1)*BlockWidth-1:0]   r_res;
    logic [(k+1)*BlockWidth-1:0]   w_res;
    logic [BlockWidth-1:0]         w_a, w_b, w_sum;
    logic                          w_vin, w_cin, w_cout;
`ifdef PIPE_CL_ADDER_FLAGS_EN
    logic                          w_zin, w_msbc, w_szero;
`endif

    if (k == 0) begin : g_src
      assign w_a   = a_i[BlockWidth-1:0];
      assign w_b   = b_i[BlockWidth-1:0] ^ {BlockWidth{sub_i}};
      assign w_vin = valid_i;
      assign w_cin = carry_i;
      assign w_res = w_sum;
`ifdef PIPE_CL_ADDER_FLAGS_EN
      assign w_zin = 1'b1;
`endif
    end else begin : g_src
      assign w_a   = g_st[k-1].g_skew.r_a[BlockWidth-1:0];
      assign w_b   = g_st[k-1].g_skew.r_b[BlockWidth-1:0];
      assign w_vin = g_st[k-1].r_st.valid;
      assign w_cin = g_st[k-1].r_st.carry;
      assign w_res = {w_sum, g_st[k-1].r_res};
`ifdef PIPE_CL_ADDER_FLAGS_EN
      assign w_zin = g_st[k-1].r_st.zero;
`endif
    end

    pipe_cl_adder_stage #(.BlockWidth(BlockWidth)) u_stage (
      .a_i         (w_a),
      .b_i         (w_b),
      .carry_i     (w_cin),
      .sum_o       (w_sum),
      .carry_o     (w_cout)
`ifdef PIPE_CL_ADDER_FLAGS_EN
      ,
      .msb_carry_o (w_msbc),
      .zero_o      (w_szero)
`endif
    );

    // skew holds only the not-yet-consumed upper slices, next slice at the bottom
    if (k < Stages - 1) begin : g_skew
      logic [Rem-1:0] r_a, r_b, w_an, w_bn;
      if (k == 0) begin : g_nxt
        assign w_an = a_i[Width-1:BlockWidth];
        assign w_bn = b_i[Width-1:BlockWidth] ^ {Rem{sub_i}};
      end else begin : g_nxt
        assign w_an = g_st[k-1].g_skew.r_a[Rem+BlockWidth-1:BlockWidth];
        assign w_bn = g_st[k-1].g_skew.r_b[Rem+BlockWidth-1:BlockWidth];
      end
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_an;
          r_b <= w_bn;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_st  <= '0;
        r_res <= '0;
      end else if (w_adv) begin
        r_st.valid     <= w_vin;
        r_st.carry     <= w_cout;
`ifdef PIPE_CL_ADDER_FLAGS_EN
        r_st.zero      <= w_zin & w_szero;
        r_st.msb_carry <= w_msbc;
`endif
        r_res          <= w_res;
      end
    end
  end

  assign valid_o  = g_st[Stages-1].r_st.valid;
  assign w_adv    = !valid_o || ready_i;
  assign ready_o  = w_adv;
  assign result_o = g_st[Stages-1].r_res;
  assign carry_o  = g_st[Stages-1].r_st.carry;
`ifdef PIPE_CL_ADDER_FLAGS_EN
  assign overflow_o = g_st[Stages-1].r_st.msb_carry ^ g_st[Stages-1].r_st.carry;
  assign zero_o     = g_st[Stages-1].r_st.zero;
`endif

endmodule
